// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline stall/flush sequencer: controller state encodings,
// the pipeline-register control bundle and helpers that apply the issue-priority rules.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MD_WAIT  = 2'b01,
    ST_MEM_WAIT = 2'b10
  } ctrl_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic ex_mem_bubble;
    logic mem_wb_write;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_write: 1'b1,
    id_ex_bubble: 1'b0, ex_mem_write: 1'b1, ex_mem_bubble: 1'b0, mem_wb_write: 1'b1};

  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b0,
    id_ex_bubble: 1'b0, ex_mem_write: 1'b0, ex_mem_bubble: 1'b0, mem_wb_write: 1'b0};

  // Front end frozen while mult/div holds EX; a NOP drains into EX/MEM behind it.
  localparam pipe_ctrl_t CTRL_MD_HOLD = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b0,
    id_ex_bubble: 1'b0, ex_mem_write: 1'b1, ex_mem_bubble: 1'b1, mem_wb_write: 1'b1};

  function automatic int md_cnt_width(input int latency);
    if (latency <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(latency);
    end
  endfunction

  function automatic pipe_ctrl_t front_end_rules(input pipe_ctrl_t base,
                                                 input logic hazard_check,
                                                 input logic imem_ready);
    pipe_ctrl_t c;
    c = base;
    if (!hazard_check) begin
      c.pc_write     = 1'b0;
      c.if_id_write  = 1'b0;
      c.id_ex_bubble = 1'b1;
    end else if (!imem_ready) begin
      c.pc_write    = 1'b0;
      c.if_id_flush = 1'b1;
    end else begin
      c = base;
    end
    return c;
  endfunction

  function automatic pipe_ctrl_t issue_rules(input logic md_start,
                                             input logic branch_taken,
                                             input logic hazard_check,
                                             input logic imem_ready);
    pipe_ctrl_t c;
    if (md_start) begin
      c = CTRL_MD_HOLD;
    end else if (branch_taken) begin
      c              = CTRL_RUN;
      c.if_id_flush  = 1'b1;
      c.id_ex_bubble = 1'b1;
    end else begin
      c = front_end_rules(CTRL_RUN, hazard_check, imem_ready);
    end
    return c;
  endfunction

endpackage

// File: rtl/md_occupancy_counter.sv
// Mult/div EX-occupancy down-counter: load on issue, decrement to 1, hold at 1, clear on release.
module md_occupancy_counter
  import mips_pipe_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic         is_last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count; the floor at 1 lets a stalled MEM stage hold the release cycle.
  always_comb begin
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (dec_i && (cnt_q > W'(1'b1))) begin
      cnt_d = cnt_q - W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_last_o = (cnt_q == W'(1'b1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline (Mealy control outputs).
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_stall_controller
  import mips_pipe_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_check,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             ex_mem_bubble,
  output logic             mem_wb_write,
  output logic             md_busy,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MD_W = md_cnt_width(MD_LATENCY);

  ctrl_state_e state_q, state_d;
  pipe_ctrl_t  ctrl_s;
  logic        md_load_s, md_dec_s, md_clr_s, md_last_s;

  // Control outputs and next state; branch is never honoured while mult/div owns EX.
  always_comb begin
    ctrl_s    = CTRL_RUN;
    state_d   = state_q;
    md_load_s = 1'b0;
    md_dec_s  = 1'b0;
    md_clr_s  = 1'b0;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl_s  = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
        end else begin
          ctrl_s    = issue_rules(md_start, branch_taken, hazard_check, imem_ready);
          md_load_s = md_start;
          state_d   = md_start ? ST_MD_WAIT : ST_RUN;
        end
      end
      ST_MD_WAIT: begin
        md_dec_s = !md_last_s;
        if (!dmem_ready) begin
          ctrl_s = CTRL_FREEZE;
        end else if (!md_last_s) begin
          ctrl_s = CTRL_MD_HOLD;
        end else begin
          ctrl_s   = front_end_rules(CTRL_RUN, hazard_check, imem_ready);
          md_clr_s = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: begin
        ctrl_s  = CTRL_FREEZE;
        state_d = ST_RUN;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  md_occupancy_counter #(
    .W (MD_W)
  ) u_md_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (md_load_s),
    .load_val_i (MD_W'(MD_LATENCY - 1)),
    .dec_i      (md_dec_s),
    .clr_i      (md_clr_s),
    .is_last_o  (md_last_s)
  );

  assign pc_write      = rst_n & ctrl_s.pc_write;
  assign if_id_write   = rst_n & ctrl_s.if_id_write;
  assign if_id_flush   = rst_n & ctrl_s.if_id_flush;
  assign id_ex_write   = rst_n & ctrl_s.id_ex_write;
  assign id_ex_bubble  = rst_n & ctrl_s.id_ex_bubble;
  assign ex_mem_write  = rst_n & ctrl_s.ex_mem_write;
  assign ex_mem_bubble = rst_n & ctrl_s.ex_mem_bubble;
  assign mem_wb_write  = rst_n & ctrl_s.mem_wb_write;
  assign md_busy       = (state_q == ST_MD_WAIT);
  assign ctrl_state    = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             br_flush_s;

  assign br_flush_s = (state_q != ST_MD_WAIT) && dmem_ready && !md_start && branch_taken;

  // Saturating stall / branch-flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (!ctrl_s.pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1'b1);
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (br_flush_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1'b1);
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
